// File: rtl/lc3_controller.sv
// Multi-cycle LC-3 sequencing FSM: fetch/decode/execute/memory/writeback/PC-update; one instruction per trip.
// Wait states hold on complete_instr / complete_data; br_taken is only driven during UPDATE_PC.
module lc3_controller #(
  parameter logic [3:0] RESET_STATE = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] instr,
  input  logic [2:0]  psr,
  output logic [3:0]  state,
  output logic [1:0]  mem_state,
  output logic        br_taken,
  output logic        illegal,
  output logic [15:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'h1,
    S_DECODE    = 4'h2,
    S_EXECUTE   = 4'h3,
    S_MEM_RD    = 4'h4,
    S_MEM_IND   = 4'h5,
    S_MEM_WR    = 4'h6,
    S_WRITEBACK = 4'h7,
    S_UPDATE_PC = 4'h8
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [2:0]  nzp_q, nzp_d;
  logic        br_q, br_d;
  logic        illegal_q, illegal_d;
  logic [15:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= state_t'(RESET_STATE);
      op_q      <= 4'h0;
      nzp_q     <= 3'b000;
      br_q      <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      nzp_q     <= nzp_d;
      br_q      <= br_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    op_d      = op_q;
    nzp_d     = nzp_q;
    br_d      = br_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    case (state_q)
      S_FETCH: begin
        if (complete_instr) begin
          op_d    = instr[15:12];
          nzp_d   = instr[11:9];
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        // Branch decision is frozen here so later psr changes cannot affect it.
        br_d = 1'b0;
        case (op_q)
          4'b0001, 4'b0101, 4'b1001, 4'b1110: state_d = S_WRITEBACK;
          4'b0100: begin state_d = S_WRITEBACK; br_d = 1'b1; end
          4'b0010, 4'b0110: state_d = S_MEM_RD;
          4'b1111: begin state_d = S_MEM_RD; br_d = 1'b1; end
          4'b1010, 4'b1011: state_d = S_MEM_IND;
          4'b0011, 4'b0111: state_d = S_MEM_WR;
          4'b0000: begin state_d = S_UPDATE_PC; br_d = |(nzp_q & psr); end
          4'b1100: begin state_d = S_UPDATE_PC; br_d = 1'b1; end
          default: begin state_d = S_UPDATE_PC; illegal_d = 1'b1; end
        endcase
      end
      S_MEM_IND: begin
        if (complete_data) state_d = (op_q == 4'b1011) ? S_MEM_WR : S_MEM_RD;
        else               state_d = S_MEM_IND;
      end
      S_MEM_RD:    state_d = complete_data ? S_WRITEBACK : S_MEM_RD;
      S_MEM_WR:    state_d = complete_data ? S_UPDATE_PC : S_MEM_WR;
      S_WRITEBACK: state_d = S_UPDATE_PC;
      S_UPDATE_PC: begin
        count_d = count_q + 16'h0001;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (state_q)
      S_MEM_RD:  mem_state = 2'd0;
      S_MEM_WR:  mem_state = 2'd1;
      S_MEM_IND: mem_state = 2'd2;
      default:   mem_state = 2'd3;
    endcase
  end

  assign state       = state_q;
  assign br_taken    = br_q && (state_q == S_UPDATE_PC);
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_lc3_controller.sv
// Self-checking bench for lc3_controller: directed scenarios plus random instruction streams
// compared cycle-by-cycle against a trace model built from the opcode path rules.
module tb_lc3_controller;

  logic        clk;
  logic        rst;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] instr;
  logic [2:0]  psr;
  logic [3:0]  state;
  logic [1:0]  mem_state;
  logic        br_taken;
  logic        illegal;
  logic [15:0] instr_count;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] m_cnt;
  logic        m_ill;

  logic [3:0] exp_st[$];
  logic       exp_ci[$];
  logic       exp_cd[$];

  lc3_controller #(.RESET_STATE(4'h1)) dut (
    .clk(clk), .rst(rst), .complete_instr(complete_instr), .complete_data(complete_data),
    .instr(instr), .psr(psr), .state(state), .mem_state(mem_state), .br_taken(br_taken),
    .illegal(illegal), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] exp_mem(input logic [3:0] st);
    case (st)
      4'h4:    return 2'd0;
      4'h6:    return 2'd1;
      4'h5:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Append a wait state lasting waits+1 cycles; complete_data rises on its last cycle.
  task automatic add_wait(input logic [3:0] st, input int waits);
    for (int i = 0; i <= waits; i++) begin
      exp_st.push_back(st);
      exp_ci.push_back(1'($urandom));
      exp_cd.push_back(i == waits);
    end
  endtask

  task automatic add_plain(input logic [3:0] st);
    exp_st.push_back(st);
    exp_ci.push_back(1'($urandom));
    exp_cd.push_back(1'($urandom));
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    complete_instr = 1'b0;
    complete_data = 1'b0;
    instr = 16'h0000;
    psr = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_cnt = 16'h0000;
    m_ill = 1'b0;
  endtask

  // Called at posedge+1 with the DUT in FETCH; leaves it at posedge+1 back in FETCH.
  task automatic run_instr(input logic [15:0] ins, input logic [2:0] p,
                           input int fw, input int dw1, input int dw2);
    logic [3:0] op;
    logic       taken;
    logic       bad;
    int         ex_idx;
    op = ins[15:12];
    exp_st.delete(); exp_ci.delete(); exp_cd.delete();
    for (int i = 0; i <= fw; i++) begin
      exp_st.push_back(4'h1);
      exp_ci.push_back(i == fw);
      exp_cd.push_back(1'($urandom));
    end
    add_plain(4'h2);
    add_plain(4'h3);
    case (op)
      4'h1, 4'h5, 4'h9, 4'hE, 4'h4: add_plain(4'h7);
      4'h2, 4'h6, 4'hF: begin add_wait(4'h4, dw1); add_plain(4'h7); end
      4'hA: begin add_wait(4'h5, dw1); add_wait(4'h4, dw2); add_plain(4'h7); end
      4'hB: begin add_wait(4'h5, dw1); add_wait(4'h6, dw2); end
      4'h3, 4'h7: add_wait(4'h6, dw1);
      default: ;
    endcase
    add_plain(4'h8);
    taken  = (op == 4'h0) ? |(ins[11:9] & p) : (op == 4'hC || op == 4'h4 || op == 4'hF);
    bad    = (op == 4'h8 || op == 4'hD);
    ex_idx = fw + 2;
    for (int k = 0; k < exp_st.size(); k++) begin
      chk("state", 16'(state), 16'(exp_st[k]));
      chk("mem_state", 16'(mem_state), 16'(exp_mem(exp_st[k])));
      chk("br_taken", 16'(br_taken), 16'(taken && exp_st[k] == 4'h8));
      chk("illegal", 16'(illegal), 16'(m_ill || (bad && k > ex_idx)));
      chk("instr_count", instr_count, m_cnt);
      complete_instr = exp_ci[k];
      complete_data  = exp_cd[k];
      instr = (exp_st[k] == 4'h1 && exp_ci[k]) ? ins : 16'($urandom);
      psr   = (k == ex_idx) ? p : 3'($urandom);
      @(posedge clk);
      #1;
    end
    complete_instr = 1'b0;
    m_cnt = m_cnt + 16'h0001;
    m_ill = m_ill | bad;
  endtask

  initial begin
    apply_reset();
    chk("rst_state", 16'(state), 16'h1);
    chk("rst_mem_state", 16'(mem_state), 16'h3);
    chk("rst_br", 16'(br_taken), 16'h0);
    chk("rst_illegal", 16'(illegal), 16'h0);
    chk("rst_count", instr_count, 16'h0);

    run_instr(16'h1021, 3'b000, 0, 0, 0);
    run_instr(16'h0402, 3'b010, 0, 0, 0);
    run_instr(16'h0402, 3'b001, 0, 0, 0);
    run_instr(16'hA000, 3'b000, 0, 3, 0);
    run_instr(16'h7000, 3'b000, 4, 0, 0);
    run_instr(16'hD000, 3'b111, 0, 0, 0);
    run_instr(16'h1021, 3'b000, 1, 0, 0);
    run_instr(16'hB000, 3'b000, 0, 2, 1);
    chk("count_after_directed", instr_count, 16'd8);

    // Abandon a pending data read with an asynchronous reset.
    complete_instr = 1'b1;
    complete_data  = 1'b0;
    instr = 16'h2000;
    repeat (3) begin
      @(posedge clk);
      #1;
      complete_instr = 1'b0;
    end
    chk("pre_rst_state", 16'(state), 16'h4);
    #2 rst = 1'b0;
    #1;
    chk("async_state", 16'(state), 16'h1);
    chk("async_mem_state", 16'(mem_state), 16'h3);
    chk("async_illegal", 16'(illegal), 16'h0);
    chk("async_count", instr_count, 16'h0);
    chk("async_br", 16'(br_taken), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_state", 16'(state), 16'h1);
    m_cnt = 16'h0000;
    m_ill = 1'b0;

    // Preload the retired count to 16'hFFFF through the counter's next-value net.
    complete_instr = 1'b0;
    force dut.count_d = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.count_d;
    #1;
    chk("preload_count", instr_count, 16'hFFFF);
    m_cnt = 16'hFFFF;
    run_instr(16'h5020, 3'b000, 0, 0, 0);
    chk("wrap_count", instr_count, 16'h0000);

    for (int n = 0; n < 80; n++) begin
      run_instr(16'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    chk("final_state", 16'(state), 16'h1);
    chk("final_count", instr_count, m_cnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lc3_controller.md
# lc3_controller

Central sequencing FSM for the multi-cycle LC-3 core. It drives the 4-bit `state` bus consumed by `fetch` and the other stage units, and waits on instruction and data memory handshakes. It decodes the latched opcode to choose the memory path, and produces `br_taken` for the fetch unit's PC mux. It also counts retired instructions.

## Interface
Parameters:
- `RESET_STATE`, 4'h1, state entered on reset (FETCH).

Ports:
- `clk`, in, 1, single clock. All state changes on the rising edge.
- `rst`, in, 1, asynchronous, active-low reset.
- `complete_instr`, in, 1, instruction memory has `instr` valid this cycle.
- `complete_data`, in, 1, data memory access finished this cycle.
- `instr`, in, 16, instruction memory read data.
- `psr`, in, 3, condition codes {N,Z,P} from writeback.
- `state`, out, 4, current controller state (encoding below).
- `mem_state`, out, 2, data memory mode: 0 read, 1 write, 2 indirect read, 3 idle.
- `br_taken`, out, 1, selects `taddr` for the PC update.
- `illegal`, out, 1, sticky flag for an unsupported opcode.
- `instr_count`, out, 16, number of retired instructions.

## Operation
- State encodings:
  - FETCH 4'h1
  - DECODE 4'h2
  - EXECUTE 4'h3
  - MEM_RD 4'h4
  - MEM_IND 4'h5
  - MEM_WR 4'h6
  - WRITEBACK 4'h7
  - UPDATE_PC 4'h8
- Unused codes go to FETCH on the next edge.
- FETCH: hold until `complete_instr`=1. On that edge, latch `op`=`instr[15:12]` and `nzp`=`instr[11:9]`, then go to DECODE.
- DECODE goes to EXECUTE unconditionally.
- EXECUTE dispatches on the latched `op`:
  - ADD/AND/NOT/LEA (0001/0101/1001/1110) and JSR (0100) go to WRITEBACK.
  - LD/LDR (0010/0110) and TRAP (1111) go to MEM_RD.
  - LDI/STI (1010/1011) go to MEM_IND.
  - ST/STR (0011/0111) go to MEM_WR.
  - BR/JMP (0000/1100) go to UPDATE_PC.
  - RTI/reserved (1000/1101): set `illegal`, go to UPDATE_PC with no branch.
- Branch flag, registered on the EXECUTE exit edge:
  - BR: |(`nzp` & `psr`), using `psr` sampled in EXECUTE.
  - JMP, JSR, TRAP: 1.
  - All other opcodes: 0.
- MEM_IND: hold until `complete_data`. Then LDI goes to MEM_RD and STI goes to MEM_WR.
- MEM_RD: hold until `complete_data`, then go to WRITEBACK.
- MEM_WR: hold until `complete_data`, then go to UPDATE_PC.
- WRITEBACK goes to UPDATE_PC.
- UPDATE_PC: `instr_count` increments (mod 2^16, FFFF wraps to 0000), then go to FETCH.
- `br_taken` = branch flag AND (`state`==UPDATE_PC). It is 0 in every other state.
- `mem_state` is combinational from `state`:
  - 0 in MEM_RD.
  - 1 in MEM_WR.
  - 2 in MEM_IND.
  - 3 otherwise.
- `illegal` is cleared only by reset.
- `complete_instr` and `complete_data` are ignored outside their wait states.

## Timing
- Reset values: `state`=4'h1, branch flag 0, `br_taken`=0, `mem_state`=3, `illegal`=0, `instr_count`=0, `op`=0, `nzp`=0.
- Reset asserted mid-instruction forces FETCH asynchronously. Any pending memory wait is abandoned.
- Minimum instruction latency with `complete_instr` high on the first FETCH cycle:
  - ALU op: 5 cycles (F, D, E, WB, UPC).
  - BR: 4 cycles.
  - LD with zero-wait data: 6 cycles.
  - LDI with zero-wait data: 7 cycles.
- Each cycle a handshake is late adds one cycle in its wait state.
- `br_taken` is high for exactly one cycle per taken branch, coincident with UPDATE_PC.
- If the fetch unit samples on that edge, the new PC equals `taddr` in the following FETCH.

## Test plan
- Reset then ADD (`instr`=16'h1021), `complete_instr` on cycle 1 → `state` sequence 1,2,3,7,8,1; `br_taken` stays 0; `instr_count`=1.
- BRz (16'h0402) with `psr`=3'b010 → `br_taken`=1 only in state 8. Repeat with `psr`=3'b001 → `br_taken` stays 0.
- LDI (16'hA000) with `complete_data` delayed 3 cycles in MEM_IND and 0 in MEM_RD → `mem_state` reads 2,2,2,2 then 0, and `state` goes 5 then 4 then 7 then 8.
- STR (16'h7000) with `complete_instr` low for 4 cycles → `state` holds 1 for 4 cycles, then 2,3,6,8. `mem_state`=1 in state 6.
- Opcode 1101 → `illegal`=1 and remains set across following instructions; `br_taken` stays 0.
- Deassert-assert `rst` while in MEM_RD → outputs return to reset values immediately, and the next cycle after release is FETCH. Separately, preload 65535 retired instructions; the next instruction's UPDATE_PC wraps `instr_count` to 0.
